// File: rtl/adder_tree_mxn_pkg.sv
// Shared helpers for the MxN adder tree: ceil-log2, per-level node counts and
// the bit offsets used to slice the packed input and output buses.
package adder_tree_mxn_pkg;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem = value - 1;
        while (rem > 0) begin
            result++;
            rem = rem >> 1;
        end
        return result;
    endfunction

    // Nodes remaining after lvl pairwise reductions (an odd leftover survives).
    function automatic int level_count(input int terms, input int lvl);
        return (terms + (1 << lvl) - 1) >> lvl;
    endfunction

    function automatic int term_offset(input int lanes, input int w, input int lane, input int term);
        return (term * lanes + lane) * w;
    endfunction

    function automatic int lane_offset(input int acc_w, input int lane);
        return lane * acc_w;
    endfunction

endpackage

// File: rtl/adder_tree_lane.sv
// One lane: a registered pairwise reduction tree over TERMS signed addends,
// followed by a saturating group accumulator with a sticky overflow flag.
module adder_tree_lane
    import adder_tree_mxn_pkg::*;
#(
    parameter int TERMS = 6,
    parameter int W     = 32,
    parameter int ACC_W = 40
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic               acc_fire_i,
    input  logic               start_i,
    input  logic [TERMS*W-1:0] terms_i,
    output logic [ACC_W-1:0]   sum_o,
    output logic               ovf_o
);

    localparam int D  = clog2(TERMS);
    localparam int TW = W + D;

    // Level l holds N nodes of width W+l; an odd leftover is paired with zero.
    for (genvar l = 1; l <= D; l++) begin : g_lvl
        localparam int NP = level_count(TERMS, l - 1);
        localparam int N  = level_count(TERMS, l);

        logic [W+l-2:0] src [2*N];
        logic [W+l-1:0] node_q [N];

        if (l == 1) begin : g_in
            always_comb begin
                for (int s = 0; s < 2 * N; s++) src[s] = '0;
                for (int s = 0; s < NP; s++) src[s] = terms_i[s*W +: W];
            end
        end else begin : g_prev
            always_comb begin
                for (int s = 0; s < 2 * N; s++) src[s] = '0;
                for (int s = 0; s < NP; s++) src[s] = g_lvl[l-1].node_q[s];
            end
        end

        always_ff @(posedge clk) begin
            if (en_i) begin
                for (int n = 0; n < N; n++) begin
                    node_q[n] <= {src[2*n][W+l-2], src[2*n]}
                               + {src[2*n+1][W+l-2], src[2*n+1]};
                end
            end
        end
    end

    logic [TW-1:0]    tree;
    logic [ACC_W:0]   treeExt;
    logic [ACC_W:0]   base;
    logic [ACC_W:0]   sumWide;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             sat;

    assign tree    = g_lvl[D].node_q[0];
    assign treeExt = {{(ACC_W + 1 - TW){tree[TW-1]}}, tree};

    // One spare bit detects overflow; clamp to the signed ACC_W range.
    always_comb begin
        base    = start_i ? '0 : {acc_q[ACC_W-1], acc_q};
        sumWide = base + treeExt;
        acc_d   = sumWide[ACC_W-1:0];
        sat     = 1'b0;
        if (sumWide[ACC_W] != sumWide[ACC_W-1]) begin
            sat   = 1'b1;
            acc_d = sumWide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
        ovf_d = (start_i ? 1'b0 : ovf_q) | sat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (acc_fire_i) begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign sum_o = acc_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/adder_tree_mxn.sv
// LANES parallel adder-tree accumulators sharing one valid/last pipeline,
// group tracking and a ready/valid handshake that freezes on output stall.
module adder_tree_mxn
    import adder_tree_mxn_pkg::*;
#(
    parameter int LANES = 6,
    parameter int TERMS = 6,
    parameter int W     = 32,
    parameter int ACC_W = 40
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    input  logic [LANES*TERMS*W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*ACC_W-1:0]   out_sum,
    output logic [LANES-1:0]         out_ovf
);

    localparam int D = clog2(TERMS);

    logic [D-1:0] vld_q, vld_d;
    logic [D-1:0] last_q, last_d;
    logic         groupOpen_q, groupOpen_d;
    logic         outValid_q, outValid_d;
    logic         adv;
    logic         accFire;

    assign adv      = !(outValid_q && !out_ready);
    assign in_ready = adv;
    assign accFire  = adv && vld_q[D-1];

    // Valid/last travel alongside the tree levels; bubbles carry valid=0.
    always_comb begin
        vld_d       = vld_q;
        last_d      = last_q;
        groupOpen_d = groupOpen_q;
        outValid_d  = outValid_q;
        if (adv) begin
            vld_d[0]  = in_valid;
            last_d[0] = in_valid && in_last;
            for (int k = 1; k < D; k++) begin
                vld_d[k]  = vld_q[k-1];
                last_d[k] = last_q[k-1];
            end
            outValid_d = vld_q[D-1] && last_q[D-1];
        end
        if (accFire) groupOpen_d = !last_q[D-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q       <= '0;
            last_q      <= '0;
            groupOpen_q <= 1'b0;
            outValid_q  <= 1'b0;
        end else begin
            vld_q       <= vld_d;
            last_q      <= last_d;
            groupOpen_q <= groupOpen_d;
            outValid_q  <= outValid_d;
        end
    end

    assign out_valid = outValid_q;

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [TERMS*W-1:0] laneTerms;
        logic [ACC_W-1:0]   laneSum;
        logic               laneOvf;

        always_comb begin
            laneTerms = '0;
            for (int t = 0; t < TERMS; t++) begin
                laneTerms[t*W +: W] = in_data[term_offset(LANES, W, j, t) +: W];
            end
        end

        adder_tree_lane #(
            .TERMS (TERMS),
            .W     (W),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .en_i       (adv),
            .acc_fire_i (accFire),
            .start_i    (!groupOpen_q),
            .terms_i    (laneTerms),
            .sum_o      (laneSum),
            .ovf_o      (laneOvf)
        );

        assign out_sum[lane_offset(ACC_W, j) +: ACC_W] = laneSum;
        assign out_ovf[j] = laneOvf;
    end

endmodule

// File: doc/adder_tree_mxn.md
ADDER_TREE_MXN -- requirements
Module: adder_tree_mxn

Interface
REQ-001 Parameter LANES, default 6: number of independent sums produced per beat.
REQ-002 Parameter TERMS, default 6: number of addends reduced per lane; SHALL be >= 2.
REQ-003 Parameter W, default 32: addend width, signed two's complement.
REQ-004 Parameter ACC_W, default 40: accumulator and output width per lane; SHALL be >= W + clog2(TERMS).
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 in_valid  input  1  in_data holds a beat.
REQ-008 in_ready  output  1  block accepts a beat this cycle.
REQ-009 in_last  input  1  beat closes the current accumulation group; qualified by in_valid.
REQ-010 in_data  input  LANES*TERMS*W  term t of lane j at bit offset (t*LANES + j)*W.
REQ-011 out_valid  output  1  out_sum holds a finished group result.
REQ-012 out_ready  input  1  consumer accepts out_sum.
REQ-013 out_sum  output  LANES*ACC_W  lane j at offset j*ACC_W.
REQ-014 out_ovf  output  LANES  lane j saturated at some point in the emitted group.

Function
REQ-015 A beat SHALL transfer when in_valid && in_ready; out SHALL transfer when out_valid && out_ready.
REQ-016 Tree: D = clog2(TERMS) registered levels; each level adds pairs and passes an odd leftover through unchanged; internal widths grow by 1 bit per level and are sign-extended, so the tree never overflows.
REQ-017 Accumulate stage: one register level after the tree; acc_j <= (group_open ? acc_j : 0) + tree_j, saturating to signed ACC_W min/max.
REQ-018 group_open SHALL clear after a beat with in_last reaches the accumulate stage and set after any other beat does.
REQ-019 On saturation in lane j, out_ovf[j] SHALL set sticky for the group and clear when the next group starts.
REQ-020 Latency: a beat with in_last accepted in cycle N SHALL produce out_valid in cycle N+D+1 when no stall occurs.
REQ-021 Beats without in_last SHALL NOT raise out_valid; a group of one beat SHALL output that beat's tree sum.
REQ-022 Stall: while out_valid && !out_ready the whole pipeline SHALL freeze, in_ready SHALL be 0, and out_sum/out_ovf SHALL stay stable.
REQ-023 Otherwise in_ready = 1; throughput one beat per cycle, including back-to-back single-beat groups.
REQ-024 Pipeline bubbles (in_valid = 0) SHALL advance as empty slots and SHALL NOT change acc or group_open.
REQ-025 A beat entering the accumulate stage in the same cycle the previous group is emitted SHALL start a new group from zero.

Reset
REQ-026 On rst: out_valid = 0, out_sum = 0, out_ovf = 0, all stage valid bits = 0, group_open = 0, acc = 0; in_ready = 1 in the first cycle after reset.
REQ-027 rst during a partial group or a stall SHALL discard all in-flight data; no result of that group SHALL ever be emitted.

Structure
REQ-028 A shared package SHALL hold the clog2 function and the lane/term bit-offset helpers.
REQ-029 One sub-module adder_tree_lane (one lane: D tree levels plus accumulator) SHALL be instantiated LANES times; the top holds the shared stage-valid shift chain, group_open, and the handshake.

Verification
REQ-030 Defaults, one beat, in_last=1, all terms = 1 -> after D+1 = 4 cycles out_valid=1, every lane out_sum = 6, out_ovf = 0.
REQ-031 Group of 3 beats, lane j terms = j+1 per beat -> a single out_valid, lane j = 18*(j+1); no output on beats 1 and 2.
REQ-032 ACC_W=W+3=35, all terms = 0x7FFFFFFF for 2 beats -> out_sum = 2^34-1 saturated, out_ovf = all ones; next group of 1s -> 6, out_ovf = 0.
REQ-033 out_ready=0 for 5 cycles with continuous input -> in_ready=0 during the stall, out_sum stable, no beat lost or duplicated after release.
REQ-034 rst asserted mid-group after 2 of 4 beats -> no out_valid; a fresh group afterwards sums from zero.
REQ-035 TERMS=5, LANES=3, negative terms -3,-3,-3,-3,-3 -> lane sum = -15, sign-correct, latency D+1 = 4.
